// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and select sequencer for the six-input operand mux
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic       out_ready,
    output logic [5:0] grant,
    output logic [2:0] sel,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [5:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;

    logic       owner_req;
    logic       transfer;
    logic       release_now;
    logic [2:0] ptr_after;
    logic [2:0] search_start;
    logic       pick_found;
    logic [2:0] pick_idx;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    // Returns {found, index}: first set bit of mask walking start, start+1, ... modulo 6.
    function automatic logic [3:0] rr_pick(input logic [5:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        logic [2:0] win;
        idx   = start;
        found = 1'b0;
        win   = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_idx(idx);
        end
        return {found, win};
    endfunction

    assign owner_req    = |(grant_q & req);
    assign transfer     = (state_q == S_GRANT) && owner_req && out_ready;
    assign release_now  = (state_q == S_GRANT) &&
                          (!owner_req || (transfer && (hold_q == HOLD_LAST)));
    assign ptr_after    = next_idx(sel_q);
    // On release the search already starts past the outgoing owner, so a sole
    // requester released by the hold limit is found last and re-granted.
    assign search_start = (state_q == S_GRANT) ? ptr_after : ptr_q;
    assign {pick_found, pick_idx} = rr_pick(req, search_start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 6'b0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_GRANT;
                    grant_d = 6'(1) << pick_idx;
                    sel_d   = pick_idx;
                    hold_d  = 4'd0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    ptr_d  = ptr_after;
                    hold_d = 4'd0;
                    if (pick_found) begin
                        grant_d = 6'(1) << pick_idx;
                        sel_d   = pick_idx;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 6'b0;
                        sel_d   = 3'd0;
                    end
                end else if (transfer && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_GRANT);
        out_valid = (state_q == S_GRANT) && owner_req;
        grant     = grant_q;
        sel       = sel_q;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter with a behavioural owner/count model
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [5:0] req;
    logic       out_ready;
    logic [5:0] grant;
    logic [2:0] sel;
    logic       out_valid;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit started = 0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int start);
        for (int k = 0; k < 6; k++) begin
            if (req[(start + k) % 6]) return (start + k) % 6;
        end
        return -1;
    endfunction

    // Model: who owns the mux, how many words it has moved, and whose turn is next.
    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            started = 1;
        end else if (m_owner < 0) begin
            m_owner = pick(m_ptr);
            m_cnt   = 0;
        end else begin
            if (!req[m_owner] || (out_ready && (m_cnt + 1 == MAX_HOLD))) begin
                m_ptr   = (m_owner + 1) % 6;
                m_owner = pick(m_ptr);
                m_cnt   = 0;
            end else if (out_ready) begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_grant", int'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
            check("model_sel", int'(sel), (m_owner < 0) ? 0 : m_owner);
            check("model_busy", int'(busy), (m_owner < 0) ? 0 : 1);
            check("model_out_valid", int'(out_valid), (m_owner < 0) ? 0 : int'(req[m_owner]));
        end
    end

    task automatic tick(input logic rst, input logic [5:0] r, input logic o);
        @(posedge clk);
        #1;
        reset     = rst;
        req       = r;
        out_ready = o;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 6'b0;
        out_ready = 1'b0;

        // Reset then single requester, hold-limit re-grant, idle return
        tick(1, 6'b0, 0);
        tick(1, 6'b0, 0);
        check("rst_grant", int'(grant), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        tick(0, 6'b000100, 1);
        check("single_idle_cycle", int'(busy), 0);
        tick(0, 6'b000100, 1);
        check("single_grant", int'(grant), 6'b000100);
        check("single_sel", int'(sel), 2);
        check("single_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) tick(0, 6'b000100, 1);
        tick(0, 6'b000100, 1);
        check("single_regrant", int'(grant), 6'b000100);
        check("single_ptr", m_ptr, 3);
        tick(0, 6'b0, 1);
        check("drop_valid", int'(out_valid), 0);
        tick(0, 6'b0, 1);
        check("idle_busy", int'(busy), 0);
        check("idle_grant", int'(grant), 0);
        check("idle_sel", int'(sel), 0);

        // All requesting: 0..5 then wrap to 0, four cycles each
        tick(1, 6'b0, 0);
        tick(0, 6'b111111, 1);
        for (int i = 0; i < 28; i++) begin
            tick(0, 6'b111111, 1);
            check("rr_sel", int'(sel), (i / 4) % 6);
            check("rr_grant", int'(grant), 1 << ((i / 4) % 6));
        end

        // Reset while input 4 holds the grant
        tick(1, 6'b0, 0);
        tick(0, 6'b111111, 1);
        for (int i = 0; i < 17; i++) tick(0, 6'b111111, 1);
        check("pre_rst_grant", int'(grant), 6'b010000);
        tick(1, 6'b111111, 1);
        tick(0, 6'b111111, 1);
        check("midrst_grant", int'(grant), 0);
        check("midrst_sel", int'(sel), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        tick(0, 6'b111111, 1);
        check("post_rst_grant", int'(grant), 6'b000001);

        // Early drop of input 3 hands over to input 5
        tick(1, 6'b0, 0);
        tick(0, 6'b001000, 1);
        tick(0, 6'b101000, 1);
        check("drop_own3", int'(sel), 3);
        tick(0, 6'b101000, 1);
        tick(0, 6'b100000, 1);
        check("drop_hold3", int'(grant), 6'b001000);
        check("drop_novalid", int'(out_valid), 0);
        tick(0, 6'b100000, 1);
        check("drop_grant5", int'(grant), 6'b100000);
        check("drop_sel5", int'(sel), 5);
        check("drop_ptr", m_ptr, 4);
        tick(0, 6'b0, 1);
        tick(0, 6'b0, 1);

        // Stall: grant to 1 holds through out_ready low, then four transfers
        tick(1, 6'b0, 0);
        tick(0, 6'b000110, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 6'b000110, 0);
            check("stall_grant", int'(grant), 6'b000010);
            check("stall_valid", int'(out_valid), 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 6'b000110, 1);
            check("xfer_grant", int'(grant), 6'b000010);
        end
        tick(0, 6'b000110, 1);
        check("stall_next_grant", int'(grant), 6'b000100);
        check("stall_next_sel", int'(sel), 2);

        // Request raised on the releasing edge joins that arbitration
        tick(1, 6'b0, 0);
        tick(0, 6'b000001, 1);
        for (int i = 0; i < 3; i++) tick(0, 6'b000001, 1);
        tick(0, 6'b000101, 1);
        check("simul_hold0", int'(grant), 6'b000001);
        tick(0, 6'b000101, 1);
        check("simul_grant2", int'(grant), 6'b000100);
        check("simul_ptr", m_ptr, 1);
        tick(0, 6'b0, 0);
        tick(0, 6'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
